dmem_port_arbiter: RTL and testbench

Two-master arbiter in front of the stall-based data memory model. It shares the memory's single load channel and single store channel between master 0 (core LSU) and master 1 (DMA/program loader). Each channel arbitrates independently, holds one transaction in flight, and routes the response back to the owning master.

---
 rtl/dmem_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Two-master arbiter for the data memory load and store channels.
// Each channel grants one transaction at a time and routes the response back.
module dmem_arb_chan #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic v0,
  input  logic v1,
  input  logic rr0,
  input  logic rr1,
  input  logic mem_ready,
  input  logic mem_resp_valid,
  output logic win,
  output logic rdy0,
  output logic rdy1,
  output logic mem_valid,
  output logic mem_resp_ready,
  output logic rv0,
  output logic rv1
);
  typedef enum logic {IDLE, BUSY} state_t;

  state_t state;
  logic   owner;
  logic   ptr;
  logic   idle;

  assign idle = (state == IDLE);

  // ptr holds the last winner; on a tie the other master goes next
  always_comb begin
    win = v1;
    if (v0 && v1) win = FIXED_PRIO ? 1'b0 : ~ptr;
  end

  assign mem_valid = !rst && idle && (v0 || v1);
  assign rdy0 = mem_valid && !win && mem_ready;
  assign rdy1 = mem_valid && win && mem_ready;

  // stray responses are swallowed while idle or in reset
  assign mem_resp_ready = rst || idle || (owner ? rr1 : rr0);
  assign rv0 = !rst && !idle && !owner && mem_resp_valid;
  assign rv1 = !rst && !idle && owner && mem_resp_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= 1'b0;
      ptr   <= 1'b1;
    end else begin
      case (state)
        IDLE: if (mem_valid && mem_ready) begin
          owner <= win;
          ptr   <= win;
          state <= BUSY;
        end
        BUSY: if (mem_resp_valid && mem_resp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

module dmem_port_arbiter #(
  parameter int LDTAG_W    = 4,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               m0_ld_valid,
  output logic               m0_ld_ready,
  input  logic [31:0]        m0_ld_addr,
  input  logic [LDTAG_W-1:0] m0_ld_tag,
  output logic               m0_ld_resp_valid,
  input  logic               m0_ld_resp_ready,
  output logic [63:0]        m0_ld_resp_data,
  output logic [LDTAG_W-1:0] m0_ld_resp_tag,
  output logic               m0_ld_resp_err,
  input  logic               m0_st_valid,
  output logic               m0_st_ready,
  input  logic [31:0]        m0_st_addr,
  input  logic [63:0]        m0_st_wdata,
  input  logic [7:0]         m0_st_wstrb,
  output logic               m0_st_resp_valid,
  input  logic               m0_st_resp_ready,
  input  logic               m1_ld_valid,
  output logic               m1_ld_ready,
  input  logic [31:0]        m1_ld_addr,
  input  logic [LDTAG_W-1:0] m1_ld_tag,
  output logic               m1_ld_resp_valid,
  input  logic               m1_ld_resp_ready,
  output logic [63:0]        m1_ld_resp_data,
  output logic [LDTAG_W-1:0] m1_ld_resp_tag,
  output logic               m1_ld_resp_err,
  input  logic               m1_st_valid,
  output logic               m1_st_ready,
  input  logic [31:0]        m1_st_addr,
  input  logic [63:0]        m1_st_wdata,
  input  logic [7:0]         m1_st_wstrb,
  output logic               m1_st_resp_valid,
  input  logic               m1_st_resp_ready,
  output logic               mem_ld_valid,
  input  logic               mem_ld_ready,
  output logic [31:0]        mem_ld_addr,
  output logic [LDTAG_W-1:0] mem_ld_tag,
  input  logic               mem_ld_resp_valid,
  output logic               mem_ld_resp_ready,
  input  logic [63:0]        mem_ld_resp_data,
  input  logic [LDTAG_W-1:0] mem_ld_resp_tag,
  input  logic               mem_ld_resp_err,
  output logic               mem_st_valid,
  input  logic               mem_st_ready,
  output logic [31:0]        mem_st_addr,
  output logic [63:0]        mem_st_wdata,
  output logic [7:0]         mem_st_wstrb,
  input  logic               mem_st_resp_valid,
  output logic               mem_st_resp_ready
);
  logic ld_win;
  logic st_win;

  dmem_arb_chan #(.FIXED_PRIO(FIXED_PRIO)) u_ld (
    .clk(clk), .rst(rst),
    .v0(m0_ld_valid), .v1(m1_ld_valid),
    .rr0(m0_ld_resp_ready), .rr1(m1_ld_resp_ready),
    .mem_ready(mem_ld_ready),
    .mem_resp_valid(mem_ld_resp_valid),
    .win(ld_win),
    .rdy0(m0_ld_ready), .rdy1(m1_ld_ready),
    .mem_valid(mem_ld_valid),
    .mem_resp_ready(mem_ld_resp_ready),
    .rv0(m0_ld_resp_valid), .rv1(m1_ld_resp_valid)
  );

  dmem_arb_chan #(.FIXED_PRIO(FIXED_PRIO)) u_st (
    .clk(clk), .rst(rst),
    .v0(m0_st_valid), .v1(m1_st_valid),
    .rr0(m0_st_resp_ready), .rr1(m1_st_resp_ready),
    .mem_ready(mem_st_ready),
    .mem_resp_valid(mem_st_resp_valid),
    .win(st_win),
    .rdy0(m0_st_ready), .rdy1(m1_st_ready),
    .mem_valid(mem_st_valid),
    .mem_resp_ready(mem_st_resp_ready),
    .rv0(m0_st_resp_valid), .rv1(m1_st_resp_valid)
  );

  assign mem_ld_addr  = ld_win ? m1_ld_addr : m0_ld_addr;
  assign mem_ld_tag   = ld_win ? m1_ld_tag : m0_ld_tag;
  assign mem_st_addr  = st_win ? m1_st_addr : m0_st_addr;
  assign mem_st_wdata = st_win ? m1_st_wdata : m0_st_wdata;
  assign mem_st_wstrb = st_win ? m1_st_wstrb : m0_st_wstrb;

  // response payload only reaches the master that sees resp_valid
  assign m0_ld_resp_data = m0_ld_resp_valid ? mem_ld_resp_data : '0;
  assign m0_ld_resp_tag  = m0_ld_resp_valid ? mem_ld_resp_tag : '0;
  assign m0_ld_resp_err  = m0_ld_resp_valid && mem_ld_resp_err;
  assign m1_ld_resp_data = m1_ld_resp_valid ? mem_ld_resp_data : '0;
  assign m1_ld_resp_tag  = m1_ld_resp_valid ? mem_ld_resp_tag : '0;
  assign m1_ld_resp_err  = m1_ld_resp_valid && mem_ld_resp_err;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: round-robin and fixed-priority
// instances share stimulus; each test checks one of them.
module tb_dmem_port_arbiter;
  localparam int TW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic m0_ld_valid, m0_ld_resp_ready, m0_st_valid, m0_st_resp_ready;
  logic m1_ld_valid, m1_ld_resp_ready, m1_st_valid, m1_st_resp_ready;
  logic [31:0] m0_ld_addr, m1_ld_addr, m0_st_addr, m1_st_addr;
  logic [TW-1:0] m0_ld_tag, m1_ld_tag;
  logic [63:0] m0_st_wdata, m1_st_wdata;
  logic [7:0] m0_st_wstrb, m1_st_wstrb;
  logic mem_ld_ready, mem_ld_resp_valid, mem_ld_resp_err;
  logic mem_st_ready, mem_st_resp_valid;
  logic [63:0] mem_ld_resp_data;
  logic [TW-1:0] mem_ld_resp_tag;

  logic m0_ld_ready, m0_ld_resp_valid, m0_ld_resp_err;
  logic m1_ld_ready, m1_ld_resp_valid, m1_ld_resp_err;
  logic m0_st_ready, m0_st_resp_valid, m1_st_ready, m1_st_resp_valid;
  logic [63:0] m0_ld_resp_data, m1_ld_resp_data;
  logic [TW-1:0] m0_ld_resp_tag, m1_ld_resp_tag;
  logic mem_ld_valid, mem_ld_resp_ready, mem_st_valid, mem_st_resp_ready;
  logic [31:0] mem_ld_addr, mem_st_addr;
  logic [TW-1:0] mem_ld_tag;
  logic [63:0] mem_st_wdata;
  logic [7:0] mem_st_wstrb;

  logic f_m0_ld_ready, f_m0_ld_resp_valid, f_m0_ld_resp_err;
  logic f_m1_ld_ready, f_m1_ld_resp_valid, f_m1_ld_resp_err;
  logic f_m0_st_ready, f_m0_st_resp_valid;
  logic f_m1_st_ready, f_m1_st_resp_valid;
  logic [63:0] f_m0_ld_resp_data, f_m1_ld_resp_data;
  logic [TW-1:0] f_m0_ld_resp_tag, f_m1_ld_resp_tag;
  logic f_mem_ld_valid, f_mem_ld_resp_ready;
  logic f_mem_st_valid, f_mem_st_resp_ready;
  logic [31:0] f_mem_ld_addr, f_mem_st_addr;
  logic [TW-1:0] f_mem_ld_tag;
  logic [63:0] f_mem_st_wdata;
  logic [7:0] f_mem_st_wstrb;

  dmem_port_arbiter #(.LDTAG_W(TW), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst(rst),
    .m0_ld_valid(m0_ld_valid), .m0_ld_ready(m0_ld_ready),
    .m0_ld_addr(m0_ld_addr), .m0_ld_tag(m0_ld_tag),
    .m0_ld_resp_valid(m0_ld_resp_valid),
    .m0_ld_resp_ready(m0_ld_resp_ready),
    .m0_ld_resp_data(m0_ld_resp_data),
    .m0_ld_resp_tag(m0_ld_resp_tag), .m0_ld_resp_err(m0_ld_resp_err),
    .m0_st_valid(m0_st_valid), .m0_st_ready(m0_st_ready),
    .m0_st_addr(m0_st_addr), .m0_st_wdata(m0_st_wdata),
    .m0_st_wstrb(m0_st_wstrb), .m0_st_resp_valid(m0_st_resp_valid),
    .m0_st_resp_ready(m0_st_resp_ready),
    .m1_ld_valid(m1_ld_valid), .m1_ld_ready(m1_ld_ready),
    .m1_ld_addr(m1_ld_addr), .m1_ld_tag(m1_ld_tag),
    .m1_ld_resp_valid(m1_ld_resp_valid),
    .m1_ld_resp_ready(m1_ld_resp_ready),
    .m1_ld_resp_data(m1_ld_resp_data),
    .m1_ld_resp_tag(m1_ld_resp_tag), .m1_ld_resp_err(m1_ld_resp_err),
    .m1_st_valid(m1_st_valid), .m1_st_ready(m1_st_ready),
    .m1_st_addr(m1_st_addr), .m1_st_wdata(m1_st_wdata),
    .m1_st_wstrb(m1_st_wstrb), .m1_st_resp_valid(m1_st_resp_valid),
    .m1_st_resp_ready(m1_st_resp_ready),
    .mem_ld_valid(mem_ld_valid), .mem_ld_ready(mem_ld_ready),
    .mem_ld_addr(mem_ld_addr), .mem_ld_tag(mem_ld_tag),
    .mem_ld_resp_valid(mem_ld_resp_valid),
    .mem_ld_resp_ready(mem_ld_resp_ready),
    .mem_ld_resp_data(mem_ld_resp_data),
    .mem_ld_resp_tag(mem_ld_resp_tag),
    .mem_ld_resp_err(mem_ld_resp_err),
    .mem_st_valid(mem_st_valid), .mem_st_ready(mem_st_ready),
    .mem_st_addr(mem_st_addr), .mem_st_wdata(mem_st_wdata),
    .mem_st_wstrb(mem_st_wstrb),
    .mem_st_resp_valid(mem_st_resp_valid),
    .mem_st_resp_ready(mem_st_resp_ready)
  );

  dmem_port_arbiter #(.LDTAG_W(TW), .FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst(rst),
    .m0_ld_valid(m0_ld_valid), .m0_ld_ready(f_m0_ld_ready),
    .m0_ld_addr(m0_ld_addr), .m0_ld_tag(m0_ld_tag),
    .m0_ld_resp_valid(f_m0_ld_resp_valid),
    .m0_ld_resp_ready(m0_ld_resp_ready),
    .m0_ld_resp_data(f_m0_ld_resp_data),
    .m0_ld_resp_tag(f_m0_ld_resp_tag),
    .m0_ld_resp_err(f_m0_ld_resp_err),
    .m0_st_valid(m0_st_valid), .m0_st_ready(f_m0_st_ready),
    .m0_st_addr(m0_st_addr), .m0_st_wdata(m0_st_wdata),
    .m0_st_wstrb(m0_st_wstrb),
    .m0_st_resp_valid(f_m0_st_resp_valid),
    .m0_st_resp_ready(m0_st_resp_ready),
    .m1_ld_valid(m1_ld_valid), .m1_ld_ready(f_m1_ld_ready),
    .m1_ld_addr(m1_ld_addr), .m1_ld_tag(m1_ld_tag),
    .m1_ld_resp_valid(f_m1_ld_resp_valid),
    .m1_ld_resp_ready(m1_ld_resp_ready),
    .m1_ld_resp_data(f_m1_ld_resp_data),
    .m1_ld_resp_tag(f_m1_ld_resp_tag),
    .m1_ld_resp_err(f_m1_ld_resp_err),
    .m1_st_valid(m1_st_valid), .m1_st_ready(f_m1_st_ready),
    .m1_st_addr(m1_st_addr), .m1_st_wdata(m1_st_wdata),
    .m1_st_wstrb(m1_st_wstrb),
    .m1_st_resp_valid(f_m1_st_resp_valid),
    .m1_st_resp_ready(m1_st_resp_ready),
    .mem_ld_valid(f_mem_ld_valid), .mem_ld_ready(mem_ld_ready),
    .mem_ld_addr(f_mem_ld_addr), .mem_ld_tag(f_mem_ld_tag),
    .mem_ld_resp_valid(mem_ld_resp_valid),
    .mem_ld_resp_ready(f_mem_ld_resp_ready),
    .mem_ld_resp_data(mem_ld_resp_data),
    .mem_ld_resp_tag(mem_ld_resp_tag),
    .mem_ld_resp_err(mem_ld_resp_err),
    .mem_st_valid(f_mem_st_valid), .mem_st_ready(mem_st_ready),
    .mem_st_addr(f_mem_st_addr), .mem_st_wdata(f_mem_st_wdata),
    .mem_st_wstrb(f_mem_st_wstrb),
    .mem_st_resp_valid(mem_st_resp_valid),
    .mem_st_resp_ready(f_mem_st_resp_ready)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    {m0_ld_valid, m1_ld_valid, m0_st_valid, m1_st_valid} = '0;
    {m0_ld_resp_ready, m1_ld_resp_ready} = 2'b11;
    {m0_st_resp_ready, m1_st_resp_ready} = 2'b11;
    m0_ld_addr = '0; m1_ld_addr = '0; m0_st_addr = '0; m1_st_addr = '0;
    m0_ld_tag = '0; m1_ld_tag = '0;
    m0_st_wdata = 64'h1111; m1_st_wdata = 64'h2222;
    m0_st_wstrb = 8'hFF; m1_st_wstrb = 8'hFF;
    mem_ld_ready = 1'b0; mem_ld_resp_valid = 1'b0;
    mem_ld_resp_err = 1'b0; mem_ld_resp_data = '0; mem_ld_resp_tag = '0;
    mem_st_ready = 1'b0; mem_st_resp_valid = 1'b0;

    // 1: outputs gated in reset, m0 request visible right after
    m0_ld_valid = 1'b1; m0_ld_addr = 32'h1000;
    mem_ld_ready = 1'b1; mem_ld_resp_valid = 1'b1;
    step(); step();
    chk("t1_rst_m0_rdy", m0_ld_ready, 0);
    chk("t1_rst_m1_rdy", m1_ld_ready, 0);
    chk("t1_rst_m0_rv", m0_ld_resp_valid, 0);
    chk("t1_rst_m1_rv", m1_ld_resp_valid, 0);
    chk("t1_rst_mem_v", mem_ld_valid, 0);
    rst = 1'b0; mem_ld_ready = 1'b0; mem_ld_resp_valid = 1'b0;
    #1;
    chk("t1_mem_v", mem_ld_valid, 1);
    chk("t1_mem_addr", mem_ld_addr, 64'h1000);
    chk("t1_resp_rdy", mem_ld_resp_ready, 1);
    m0_ld_valid = 1'b0;
    step();

    // 2: lone m1 load, response routed to m1 only
    m1_ld_valid = 1'b1; m1_ld_addr = 32'h40; m1_ld_tag = 4'd5;
    mem_ld_ready = 1'b1;
    #1;
    chk("t2_addr", mem_ld_addr, 64'h40);
    chk("t2_tag", mem_ld_tag, 5);
    chk("t2_m1_rdy", m1_ld_ready, 1);
    chk("t2_m0_rdy", m0_ld_ready, 0);
    step();
    m1_ld_valid = 1'b0;
    mem_ld_resp_valid = 1'b1;
    mem_ld_resp_data = 64'hDEAD_BEEF_0123_4567;
    mem_ld_resp_tag = 4'd5;
    #1;
    chk("t2_busy_mem_v", mem_ld_valid, 0);
    chk("t2_m1_rv", m1_ld_resp_valid, 1);
    chk("t2_m1_data", m1_ld_resp_data, 64'hDEAD_BEEF_0123_4567);
    chk("t2_m1_tag", m1_ld_resp_tag, 5);
    chk("t2_m0_rv", m0_ld_resp_valid, 0);
    chk("t2_resp_rdy", mem_ld_resp_ready, 1);
    step();
    mem_ld_resp_valid = 1'b0;
    #1;
    chk("t2_m0_rv_end", m0_ld_resp_valid, 0);

    // 3: both hold valid, grants alternate starting with m0
    m0_ld_valid = 1'b1; m0_ld_addr = 32'h200; m0_ld_tag = 4'd1;
    m1_ld_valid = 1'b1; m1_ld_addr = 32'h300; m1_ld_tag = 4'd2;
    #1;
    for (int i = 0; i < 4; i++) begin
      logic w;
      w = i[0];
      chk("t3_grant_addr", mem_ld_addr, w ? 64'h300 : 64'h200);
      chk("t3_m0_rdy", m0_ld_ready, !w);
      chk("t3_m1_rdy", m1_ld_ready, w);
      step();
      mem_ld_resp_valid = 1'b1;
      mem_ld_resp_tag = 4'(i);
      #1;
      chk("t3_busy_m0_rdy", m0_ld_ready, 0);
      chk("t3_busy_m1_rdy", m1_ld_ready, 0);
      chk("t3_m0_rv", m0_ld_resp_valid, !w);
      chk("t3_m1_rv", m1_ld_resp_valid, w);
      step();
      mem_ld_resp_valid = 1'b0;
      #1;
    end
    m0_ld_valid = 1'b0; m1_ld_valid = 1'b0;

    // 4: m0 store and m1 load in flight together
    m0_st_valid = 1'b1; m0_st_addr = 32'h100; m0_st_wstrb = 8'h0F;
    m1_ld_valid = 1'b1; m1_ld_addr = 32'h80;
    mem_st_ready = 1'b1;
    #1;
    chk("t4_st_addr", mem_st_addr, 64'h100);
    chk("t4_st_wstrb", mem_st_wstrb, 8'h0F);
    chk("t4_ld_addr", mem_ld_addr, 64'h80);
    chk("t4_m0_st_rdy", m0_st_ready, 1);
    step();
    m0_st_valid = 1'b0; m1_ld_valid = 1'b0;
    mem_st_resp_valid = 1'b1; mem_ld_resp_valid = 1'b1;
    #1;
    chk("t4_st_busy", mem_st_valid, 0);
    chk("t4_ld_busy", mem_ld_valid, 0);
    chk("t4_m0_st_rv", m0_st_resp_valid, 1);
    chk("t4_m1_st_rv", m1_st_resp_valid, 0);
    chk("t4_m1_ld_rv", m1_ld_resp_valid, 1);
    chk("t4_m0_ld_rv", m0_ld_resp_valid, 0);
    step();
    mem_st_resp_valid = 1'b0; mem_ld_resp_valid = 1'b0;
    #1;

    // 5: owner backpressure blocks the channel
    m1_ld_valid = 1'b1; m1_ld_addr = 32'h44; m1_ld_tag = 4'd3;
    #1;
    chk("t5_m1_rdy", m1_ld_ready, 1);
    step();
    m1_ld_valid = 1'b0;
    m0_ld_valid = 1'b1; m0_ld_addr = 32'h200;
    m1_ld_resp_ready = 1'b0;
    mem_ld_resp_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t5_resp_rdy", mem_ld_resp_ready, 0);
      chk("t5_m0_rdy", m0_ld_ready, 0);
      chk("t5_mem_v", mem_ld_valid, 0);
      chk("t5_m1_rv", m1_ld_resp_valid, 1);
      step();
    end
    m1_ld_resp_ready = 1'b1;
    #1;
    chk("t5_resp_rdy_go", mem_ld_resp_ready, 1);
    step();
    mem_ld_resp_valid = 1'b0;
    #1;
    chk("t5_regrant_v", mem_ld_valid, 1);
    chk("t5_regrant_addr", mem_ld_addr, 64'h200);
    chk("t5_m0_rdy_go", m0_ld_ready, 1);
    step();
    m0_ld_valid = 1'b0;
    mem_ld_resp_valid = 1'b1;
    #1;
    chk("t5_m0_rv", m0_ld_resp_valid, 1);
    step();
    mem_ld_resp_valid = 1'b0;

    // 6: fixed priority, then reset while a store is outstanding
    rst = 1'b1;
    step();
    rst = 1'b0;
    m0_st_valid = 1'b1; m0_st_addr = 32'h500;
    m1_st_valid = 1'b1; m1_st_addr = 32'h600;
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("t6_fp_addr", f_mem_st_addr, 64'h500);
      chk("t6_fp_m0_rdy", f_m0_st_ready, 1);
      chk("t6_fp_m1_rdy", f_m1_st_ready, 0);
      step();
      mem_st_resp_valid = 1'b1;
      #1;
      chk("t6_fp_m0_rv", f_m0_st_resp_valid, 1);
      chk("t6_fp_m1_rv", f_m1_st_resp_valid, 0);
      step();
      mem_st_resp_valid = 1'b0;
    end
    #1;
    chk("t6_fp_m1_rdy_last", f_m1_st_ready, 0);
    step();
    rst = 1'b1;
    m0_st_valid = 1'b0; m1_st_valid = 1'b0;
    mem_st_resp_valid = 1'b1;
    #1;
    chk("t6_rst_st_v", f_mem_st_valid, 0);
    chk("t6_rst_m0_rv", f_m0_st_resp_valid, 0);
    step();
    rst = 1'b0;
    #1;
    chk("t6_drain_rdy", f_mem_st_resp_ready, 1);
    chk("t6_drain_m0_rv", f_m0_st_resp_valid, 0);
    chk("t6_drain_m1_rv", f_m1_st_resp_valid, 0);
    step();
    mem_st_resp_valid = 1'b0;
    #1;
    chk("t6_idle_st_v", f_mem_st_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
